// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: bus widths, response codes and the
// channel FSM state types used by the register-file slave.
package axil_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

endpackage

// File: rtl/axil_regfile_wstrb_merge.sv
// Byte-lane merge: each byte takes the new data where its strobe is set,
// otherwise keeps the old register contents. Purely combinational.
module axil_regfile_wstrb_merge
  import axil_pkg::*;
(
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] new_data,
  input  logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] merged
);

  for (genvar b = 0; b < STRB_W; b++) begin : g_byte
    assign merged[b*8 +: 8] = strb[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
  end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI-Lite register file slave. Low indices are software-writable control
// registers driven to hardware; the remaining indices read back hardware
// status. Write and read channels run independent two-state FSMs with one
// outstanding transaction each.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int                NUM_REGS    = 16,
  parameter int                NUM_RW      = 8,
  parameter logic [DATA_W-1:0] RESET_VALUE = 32'h0000_0000,
  localparam int               NUM_ST      = (NUM_REGS > NUM_RW) ? NUM_REGS - NUM_RW : 1
)(
  input  logic                           aclk,
  input  logic                           aresetn,
  // write address
  input  logic [ADDR_W-1:0]              s_axil_awaddr,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  // write data
  input  logic [DATA_W-1:0]              s_axil_wdata,
  input  logic [STRB_W-1:0]              s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  // write response
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  // read address
  input  logic [ADDR_W-1:0]              s_axil_araddr,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  // read data
  output logic [DATA_W-1:0]              s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  // hardware side
  output logic [NUM_RW-1:0][DATA_W-1:0]  ctrl_regs,
  output logic [NUM_RW-1:0]              ctrl_wr_pulse,
  input  logic [NUM_ST-1:0][DATA_W-1:0]  status_regs
);

  localparam int IDX_W = $clog2(NUM_REGS);

  w_state_t w_state;
  r_state_t r_state;

  // write-side holding registers: AW and W may arrive in either order
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;
  logic [NUM_RW-1:0] wr_hit;
  logic              wr_ok;

  logic [NUM_RW-1:0][DATA_W-1:0]   merged;
  logic [NUM_REGS-1:0][DATA_W-1:0] reg_view;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid  & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  // The final handshake of a write commits on its own edge, so the latched
  // copy is bypassed by whichever half arrives last.
  assign wr_addr = aw_held ? awaddr_q : s_axil_awaddr;
  assign wr_data = w_held  ? wdata_q  : s_axil_wdata;
  assign wr_strb = w_held  ? wstrb_q  : s_axil_wstrb;
  assign commit  = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);

  // Upper address bits were decoded by the interconnect; byte offset is ignored.
  assign widx = wr_addr[IDX_W+1:2];
  assign ridx = s_axil_araddr[IDX_W+1:2];

  // per-register write decode and byte merge
  for (genvar i = 0; i < NUM_RW; i++) begin : g_lane
    assign wr_hit[i] = (widx == IDX_W'(i));
    axil_regfile_wstrb_merge u_merge (
      .old_data (ctrl_regs[i]),
      .new_data (wr_data),
      .strb     (wr_strb),
      .merged   (merged[i])
    );
  end

  // indices past the control block are read-only and answer SLVERR on write
  assign wr_ok = |wr_hit;

  // flat read view of the whole register space
  for (genvar j = 0; j < NUM_REGS; j++) begin : g_view
    if (j < NUM_RW) begin : g_ctrl
      assign reg_view[j] = ctrl_regs[j];
    end else begin : g_stat
      assign reg_view[j] = status_regs[j-NUM_RW];
    end
  end

  // status_regs is fully unused when every register is writable
  logic unused_bits;
  assign unused_bits = ^{wr_addr[ADDR_W-1:IDX_W+2], wr_addr[1:0],
                         s_axil_araddr[ADDR_W-1:IDX_W+2], s_axil_araddr[1:0],
                         status_regs};

  // Write channel FSM: collect AW and W, commit, then hold B until accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state        <= W_IDLE;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      s_axil_awready <= 1'b1;
      s_axil_wready  <= 1'b1;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      ctrl_regs      <= {NUM_RW{RESET_VALUE}};
      ctrl_wr_pulse  <= '0;
    end else begin
      ctrl_wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held        <= 1'b1;
            awaddr_q       <= s_axil_awaddr;
            s_axil_awready <= 1'b0;
          end
          if (w_hs) begin
            w_held        <= 1'b1;
            wdata_q       <= s_axil_wdata;
            wstrb_q       <= s_axil_wstrb;
            s_axil_wready <= 1'b0;
          end
          if (commit) begin
            for (int i = 0; i < NUM_RW; i++) begin
              if (wr_hit[i]) ctrl_regs[i] <= merged[i];
            end
            ctrl_wr_pulse  <= wr_hit;
            s_axil_bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            s_axil_bvalid  <= 1'b1;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            w_state        <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid  <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            s_axil_awready <= 1'b1;
            s_axil_wready  <= 1'b1;
            w_state        <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: sample the register on the AR edge, hold R until accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= R_IDLE;
      s_axil_arready <= 1'b1;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= RESP_OKAY;
      s_axil_rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_axil_rdata   <= reg_view[ridx];
            s_axil_rresp   <= RESP_OKAY;
            s_axil_rvalid  <= 1'b1;
            s_axil_arready <= 1'b0;
            r_state        <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid  <= 1'b0;
            s_axil_arready <= 1'b1;
            r_state        <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Bench for axil_slave_regfile: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a
// transaction-level model of the register file.
module tb_axil_slave_regfile;
  import axil_pkg::*;

  localparam int          NUM_REGS = 16;
  localparam int          NUM_RW   = 8;
  localparam int          NUM_ST   = NUM_REGS - NUM_RW;
  localparam logic [31:0] RST_VAL  = 32'h0000_0000;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [NUM_RW-1:0][31:0] ctrl_regs;
  logic [NUM_RW-1:0]       ctrl_wr_pulse;
  logic [NUM_ST-1:0][31:0] status_regs;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axil_slave_regfile #(.NUM_REGS(NUM_REGS), .NUM_RW(NUM_RW), .RESET_VALUE(RST_VAL)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .status_regs(status_regs)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0]       m_ctrl [NUM_RW];
  logic [NUM_RW-1:0] m_pulse;
  bit                m_aw_got, m_w_got, m_bpend, m_rpend;
  logic [31:0]       m_awaddr, m_wdata, m_rdata;
  logic [3:0]        m_wstrb;
  logic [1:0]        m_bresp, m_rresp;

  task automatic model_reset();
    for (int i = 0; i < NUM_RW; i++) m_ctrl[i] = RST_VAL;
    m_pulse = '0;
    m_aw_got = 0; m_w_got = 0; m_bpend = 0; m_rpend = 0;
    m_rdata = '0; m_bresp = RESP_OKAY; m_rresp = RESP_OKAY;
  endtask

  // advance the model across the next clock edge using the inputs now on the bus
  task automatic model_step();
    int ridx, widx;
    m_pulse = '0;
    // the read is evaluated before the write so it sees the pre-write contents
    if (m_rpend) begin
      if (rready) m_rpend = 0;
    end else if (arvalid) begin
      ridx = int'((araddr >> 2) % NUM_REGS);
      m_rdata = (ridx < NUM_RW) ? m_ctrl[ridx] : status_regs[ridx-NUM_RW];
      m_rresp = RESP_OKAY;
      m_rpend = 1;
    end
    if (m_bpend) begin
      if (bready) begin m_bpend = 0; m_aw_got = 0; m_w_got = 0; end
    end else begin
      if (awvalid && !m_aw_got) begin m_aw_got = 1; m_awaddr = awaddr; end
      if (wvalid && !m_w_got) begin m_w_got = 1; m_wdata = wdata; m_wstrb = wstrb; end
      if (m_aw_got && m_w_got) begin
        widx = int'((m_awaddr >> 2) % NUM_REGS);
        if (widx < NUM_RW) begin
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) m_ctrl[widx][b*8 +: 8] = m_wdata[b*8 +: 8];
          m_pulse[widx] = 1'b1;
          m_bresp = RESP_OKAY;
        end else begin
          m_bresp = RESP_SLVERR;
        end
        m_bpend = 1;
      end
    end
  endtask

  // compare on the falling edge, then step the model for the coming rising edge
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) model_reset();
      for (int i = 0; i < NUM_RW; i++) chk($sformatf("ctrl_regs[%0d]", i), ctrl_regs[i], m_ctrl[i]);
      chk("ctrl_wr_pulse", 32'(ctrl_wr_pulse), 32'(m_pulse));
      chk("bvalid",  32'(bvalid),  32'(m_bpend));
      chk("rvalid",  32'(rvalid),  32'(m_rpend));
      chk("awready", 32'(awready), 32'(!m_aw_got && !m_bpend));
      chk("wready",  32'(wready),  32'(!m_w_got && !m_bpend));
      chk("arready", 32'(arready), 32'(!m_rpend));
      if (m_bpend || !aresetn) chk("bresp", 32'(bresp), 32'(m_bresp));
      if (m_rpend || !aresetn) begin
        chk("rdata", rdata, m_rdata);
        chk("rresp", 32'(rresp), 32'(m_rresp));
      end
      if (aresetn) model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    arvalid = 1'b1; araddr = a;
    while (!arready && n < 50) begin tick(); n++; end
    chk("ar_wait_bound", 32'(n < 50), 32'd1);
    tick();
    arvalid = 1'b0;
    chk("rvalid_latency", 32'(rvalid), 32'd1);
    d = rdata; r = rresp;
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  task automatic do_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int aw_dly, input int w_dly);
    int c = 0;
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    while (!(aw_done && w_done) && c < 50) begin
      awvalid = !aw_done && (c >= aw_dly); awaddr = a;
      wvalid  = !w_done  && (c >= w_dly);  wdata = d; wstrb = s;
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      tick(); c++;
      aw_done |= aw_f;
      w_done  |= w_f;
      if (w_done && !aw_done) chk("wready_low_after_w", 32'(wready), 32'd0);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("aw_w_wait_bound", 32'(aw_done && w_done), 32'd1);
  endtask

  task automatic b_accept(output logic [1:0] r);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin tick(); n++; end
    chk("b_wait_bound", 32'(n < 50), 32'd1);
    r = bresp;
    tick();
    bready = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[5:2] = 4'($urandom_range(0, NUM_REGS-1));
    return a;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bit aw_f, w_f, ar_f;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    for (int i = 0; i < NUM_ST; i++) status_regs[i] = $urandom;
    status_regs[7] = 32'hCAFE_0001;

    aresetn = 1'b0;
    repeat (3) tick();
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready",  32'(wready),  32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_ctrl0",   ctrl_regs[0], RST_VAL);
    aresetn = 1'b1;
    tick();

    // reset contents and a status register read
    do_read(32'h0000_0000, d, r);
    chk("t1_idx0", d, RST_VAL);
    chk("t1_idx0_resp", 32'(r), 32'(RESP_OKAY));
    do_read(32'h0000_003C, d, r);
    chk("t1_idx15", d, 32'hCAFE_0001);

    // AW and W together
    do_aw_w(32'h08, 32'h1234_5678, 4'hF, 0, 0);
    chk("t2_ctrl2",  ctrl_regs[2], 32'h1234_5678);
    chk("t2_pulse",  32'(ctrl_wr_pulse), 32'h04);
    chk("t2_bvalid", 32'(bvalid), 32'd1);
    tick();
    chk("t2_pulse_one_cycle", 32'(ctrl_wr_pulse), 32'h00);
    b_accept(r);
    chk("t2_bresp", 32'(r), 32'(RESP_OKAY));

    // W first, AW three cycles later, partial strobe
    do_aw_w(32'h04, 32'hAABB_CCDD, 4'b0101, 3, 0);
    chk("t3_ctrl1",   ctrl_regs[1], 32'h00BB_00DD);
    chk("t3_wready",  32'(wready), 32'd0);
    b_accept(r);
    chk("t3_bresp",   32'(r), 32'(RESP_OKAY));
    chk("t3_wready_reopen", 32'(wready), 32'd1);

    // write to a read-only index
    do_aw_w(32'h24, 32'hFFFF_FFFF, 4'hF, 0, 1);
    chk("t4_pulse", 32'(ctrl_wr_pulse), 32'h00);
    chk("t4_ctrl1", ctrl_regs[1], 32'h00BB_00DD);
    b_accept(r);
    chk("t4_bresp", 32'(r), 32'(RESP_SLVERR));

    // B held off for five cycles while a read goes through
    do_aw_w(32'h0C, 32'h0000_0001, 4'hF, 0, 0);
    arvalid = 1'b1; araddr = 32'h08;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_bvalid_hold",  32'(bvalid),  32'd1);
      chk("t5_bresp_hold",   32'(bresp),   32'(RESP_OKAY));
      chk("t5_awready_low",  32'(awready), 32'd0);
      if (i == 0) begin
        chk("t5_rvalid", 32'(rvalid), 32'd1);
        chk("t5_rdata",  rdata, 32'h1234_5678);
        arvalid = 1'b0; rready = 1'b1;
      end
      if (i == 1) begin
        chk("t5_rdone", 32'(rvalid), 32'd0);
        rready = 1'b0;
      end
    end
    b_accept(r);
    chk("t5_awready_back", 32'(awready), 32'd1);

    // read and write the same register on one edge
    awvalid = 1'b1; awaddr = 32'h0C; wvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h0C;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t6_rdata_old", rdata, 32'h1);
    chk("t6_ctrl3_new", ctrl_regs[3], 32'h2);
    rready = 1'b1; tick(); rready = 1'b0;
    b_accept(r);
    do_read(32'h0C, d, r);
    chk("t6_rdata_new", d, 32'h2);

    // reset while a write response is pending
    do_aw_w(32'h14, 32'hDEAD_BEEF, 4'hF, 0, 0);
    chk("t7_ctrl5", ctrl_regs[5], 32'hDEAD_BEEF);
    tick();
    aresetn = 1'b0;
    #1;
    chk("t7_bvalid_drop", 32'(bvalid), 32'd0);
    chk("t7_ctrl5_rst",   ctrl_regs[5], RST_VAL);
    chk("t7_ctrl2_rst",   ctrl_regs[2], RST_VAL);
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // randomized traffic, protocol-legal (valid held until handshake)
    aw_f = 0; w_f = 0; ar_f = 0;
    for (int c = 0; c < 3000; c++) begin
      if (aw_f) awvalid = 1'b0;
      if (w_f)  wvalid  = 1'b0;
      if (ar_f) arvalid = 1'b0;
      if (!awvalid && $urandom_range(0, 2) == 0) begin awvalid = 1'b1; awaddr = rand_addr(); end
      if (!wvalid && $urandom_range(0, 2) == 0) begin
        wvalid = 1'b1; wdata = $urandom; wstrb = 4'($urandom);
      end
      if (!arvalid && $urandom_range(0, 1) == 0) begin arvalid = 1'b1; araddr = rand_addr(); end
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) status_regs[$urandom_range(0, NUM_ST-1)] = $urandom;
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      ar_f = arvalid && arready;
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard stop if the sequence ever stalls
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
